// File: rtl/ipsl_hmic_h_ddrphy_dll_iorst_seq_if.sv
// Handshake and I/O-control bundle between the DLL update controller, the
// I/O-reset sequencer and the DQS-group slices.
interface ipsl_hmic_h_ddrphy_dll_iorst_seq_if #(
  parameter int GRP_NUM = 4
);
  logic               dll_update_iorst_req;
  logic               dll_update_iorst_ack;
  logic               ioclk_gate;
  logic [GRP_NUM-1:0] iorst;
  logic               busy;

  modport master (
    output dll_update_iorst_req,
    input  dll_update_iorst_ack, ioclk_gate, iorst, busy
  );

  modport slave (
    input  dll_update_iorst_req,
    output dll_update_iorst_ack, ioclk_gate, iorst, busy
  );
endinterface

// File: rtl/ipsl_hmic_h_ddrphy_dll_iorst_seq.sv
// DQS-group I/O reset sequencer: gate clocks, pulse iorst, recover, ungate, ack.
// Define DDRPHY_IORST_STAGGER_EN to walk iorst one group at a time.
module ipsl_hmic_h_ddrphy_dll_iorst_seq #(
  parameter int GRP_NUM     = 4,
  parameter int GATE_CYCLES = 4,
  parameter int RST_CYCLES  = 8
) (
  input logic rclk,
  input logic rst_n,
  ipsl_hmic_h_ddrphy_dll_iorst_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GATE    = 3'd1,
    RST     = 3'd2,
    RECOVER = 3'd3,
    ACK     = 3'd4
  } state_t;

  // Counters are preloaded with N-1 so a phase spans exactly N edges.
  localparam logic [7:0] G_LD = 8'(GATE_CYCLES - 1);
  localparam logic [7:0] R_LD = 8'(RST_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;

`ifdef DDRPHY_IORST_STAGGER_EN
  localparam int GW = (GRP_NUM > 1) ? $clog2(GRP_NUM) : 1;
  logic [GW-1:0] grp;
`endif

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= IDLE;
      cnt                      <= '0;
      bus.dll_update_iorst_ack <= 1'b0;
      bus.ioclk_gate           <= 1'b0;
      bus.iorst                <= '0;
      bus.busy                 <= 1'b0;
`ifdef DDRPHY_IORST_STAGGER_EN
      grp                      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.dll_update_iorst_req) begin
            state          <= GATE;
            bus.ioclk_gate <= 1'b1;
            bus.busy       <= 1'b1;
            cnt            <= G_LD;
          end
        end
        GATE: begin
          if (cnt == 8'd0) begin
            state <= RST;
            cnt   <= R_LD;
`ifdef DDRPHY_IORST_STAGGER_EN
            grp       <= '0;
            bus.iorst <= GRP_NUM'(1);
`else
            bus.iorst <= '1;
`endif
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RST: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
`ifdef DDRPHY_IORST_STAGGER_EN
          // Hand over to the next group on the same edge: no gap, no overlap.
          end else if (grp != GW'(GRP_NUM - 1)) begin
            grp       <= grp + 1'b1;
            bus.iorst <= bus.iorst << 1;
            cnt       <= R_LD;
`endif
          end else begin
            state     <= RECOVER;
            bus.iorst <= '0;
            cnt       <= G_LD;
          end
        end
        RECOVER: begin
          if (cnt == 8'd0) begin
            state                    <= ACK;
            bus.ioclk_gate           <= 1'b0;
            bus.dll_update_iorst_ack <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACK: begin
          if (!bus.dll_update_iorst_req) begin
            state                    <= IDLE;
            bus.dll_update_iorst_ack <= 1'b0;
            bus.busy                 <= 1'b0;
          end
        end
        default: begin
          state                    <= IDLE;
          cnt                      <= '0;
          bus.dll_update_iorst_ack <= 1'b0;
          bus.ioclk_gate           <= 1'b0;
          bus.iorst                <= '0;
          bus.busy                 <= 1'b0;
        end
      endcase
    end
  end

endmodule
